prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- UART-driven program writer for the 16x8 instruction RAM that the 4-bit CPU fetches from; the write side of the CPU's instruction-fetch path.
- Receives a framed program over a serial line.
- Writes each byte into RAM through a single write port.
- Holds the CPU in reset while a load is in progress, and after a failed load.
- Status levels drive spare LEDs.

Parameters:
- CLK_HZ, 27000000, system clock frequency.
- BAUD, 115200, serial bit rate. DIV = CLK_HZ/BAUD, truncated (234 at defaults).
- DEPTH, 16, program RAM entries. Maximum frame length.
- TIMEOUT, 2700000, idle clocks allowed between bytes inside a frame (100 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rxd  in  1  UART receive line, idle high, asynchronous to clk
- wr_en  out  1  one-cycle RAM write strobe
- wr_addr  out  4  RAM write address
- wr_data  out  8  RAM write data
- cpu_hold  out  1  high = keep CPU in reset; combined externally with the CPU reset
- busy  out  1  high while a frame is being received
- load_ok  out  1  level: last frame completed with a good checksum
- load_err  out  1  level: last frame aborted

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, load_ok=0, load_err=0. Both FSMs return to idle. Reset mid-frame discards the frame; the CPU runs whatever is in RAM.
- Input sync: rxd passes through a 2-flop synchronizer. All following logic uses the synced value.
- UART RX, 8N1, LSB first:
  - RX_IDLE: a synced high-to-low transition loads the bit counter with DIV/2, then go to RX_START.
  - RX_START: at expiry, re-sample. If high, treat as a glitch and return to RX_IDLE. If low, reload DIV and go to RX_DATA.
  - RX_DATA: sample 8 bits, each DIV clocks apart.
  - RX_STOP: sample after DIV clocks. High = byte valid. Low = framing error; then wait for the line to return high before going to RX_IDLE.
  - byte_valid pulses for one clk in the cycle after the stop sample.
- Frame FSM, states F_SYNC, F_LEN, F_DATA, F_CHK:
  - F_SYNC: bytes other than 0xA5 are ignored. On 0xA5: cpu_hold=1, busy=1, load_ok=0, load_err=0, sum=0, idx=0, go to F_LEN.
  - F_LEN: accept LEN in 1..DEPTH. Set sum=LEN, go to F_DATA. LEN=0 or LEN>DEPTH is an abort.
  - F_DATA: each byte drives wr_en=1 for exactly one cycle, with wr_addr=idx and wr_data=byte, in the cycle after byte_valid.
    - sum = sum+byte, mod 256. idx increments.
    - After LEN bytes, go to F_CHK. Addresses idx..DEPTH-1 are left unwritten.
  - F_CHK: byte == sum means success: load_ok=1, cpu_hold=0, busy=0, go to F_SYNC. Mismatch is an abort.
- Abort rules:
  - Abort causes: bad LEN, checksum mismatch, framing error while busy, or TIMEOUT clocks with no byte_valid while busy.
  - On abort: load_err=1, busy=0, go to F_SYNC. cpu_hold stays 1 because RAM is partially written. It clears only on a later successful frame or reset.
- Framing errors while not busy are ignored and flag nothing.
- 0xA5 received inside a frame is treated as data, with no resync.
- The timeout counter resets on every byte_valid, and is held at 0 while not busy.
- wr_addr/wr_data hold their last values between strobes. wr_en is never asserted outside F_DATA.
- Writes go directly to RAM with no staging. cpu_hold guarantees the CPU never fetches during a load.

Test Plan:
- Good frame: bytes A5 03 A3 62 90, CHK=03+A3+62+90 mod 256=98, sent as 98 -> three wr_en pulses at addr 0,1,2 with data A3,62,90. After the final byte: load_ok=1, cpu_hold=0, busy=0, load_err=0.
- Bad checksum: A5 02 11 22 00 -> two writes, then load_err=1, cpu_hold=1, load_ok=0. A following good frame clears load_err and cpu_hold.
- Length bounds: A5 00 and A5 11 -> no writes, load_err=1. A5 10 followed by 16 bytes and the correct CHK -> writes at addr 0..15, load_ok=1.
- Line noise: garbage bytes 00 FF 5A before A5 -> ignored. A 0.3-bit low glitch on rxd produces no byte. A stop bit forced low mid-frame -> load_err=1.
- Timeout: A5 04 12 then silence for TIMEOUT+10 clocks -> load_err=1, busy=0, one write only.
- Reset mid-frame: assert rst after A5 02 33 -> all outputs return to reset values immediately. The next A5 starts a fresh frame at idx 0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Serial-in / RAM-write-out bundle of the program loader.
// The slave side is the loader itself; the master side drives rxd and watches the writes and status.
interface prog_loader_if;
  logic       rxd;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_hold;
  logic       busy;
  logic       load_ok;
  logic       load_err;

  modport master (
    output rxd,
    input  wr_en, wr_addr, wr_data, cpu_hold, busy, load_ok, load_err
  );

  modport slave (
    input  rxd,
    output wr_en, wr_addr, wr_data, cpu_hold, busy, load_ok, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: 8N1 UART receiver feeding a framed-program writer for the
// 16x8 instruction RAM. Frame = A5, LEN (1..DEPTH), LEN data bytes, CHK where
// CHK = (LEN + sum of data) mod 256. The CPU is held in reset while loading and
// after any aborted load, until a later frame succeeds.
module prog_loader #(
  parameter int CLK_HZ  = 27000000,
  parameter int BAUD    = 115200,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 2700000
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int IW  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {F_SYNC, F_LEN, F_DATA, F_CHK} f_state_t;

  // rxd synchronizer: p0/p1 resolve metastability, p2 is the previous synced value for edge detect
  logic rxd_p0, rxd_p1, rxd_p2;

  // Two-flop synchronizer plus one delay flop, all resetting to the idle-high line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= bus.rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  logic rx_fall;
  assign rx_fall = rxd_p2 & ~rxd_p1;

  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt, cnt_next;
  logic [2:0]      rx_bit, bit_next;
  logic [7:0]      rx_shift, shift_next;
  logic            byte_valid, valid_next;
  logic            frame_err, ferr_next;

  // UART receiver state and bit timing registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      rx_cnt     <= cnt_next;
      rx_bit     <= bit_next;
      rx_shift   <= shift_next;
      byte_valid <= valid_next;
      frame_err  <= ferr_next;
    end
  end

  // UART receiver next state: half-bit to the start centre, then one bit period per sample
  always_comb begin
    rx_next    = rx_state;
    cnt_next   = rx_cnt;
    bit_next   = rx_bit;
    shift_next = rx_shift;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          cnt_next = CW'(DIV / 2 - 1);
          rx_next  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rxd_p1) begin
            rx_next = RX_IDLE;
          end else begin
            cnt_next = CW'(DIV - 1);
            bit_next = 3'd0;
            rx_next  = RX_DATA;
          end
        end else begin
          cnt_next = rx_cnt - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          shift_next = {rxd_p1, rx_shift[7:1]};
          cnt_next   = CW'(DIV - 1);
          bit_next   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_next = RX_STOP;
        end else begin
          cnt_next = rx_cnt - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (rxd_p1) begin
            valid_next = 1'b1;
            rx_next    = RX_IDLE;
          end else begin
            ferr_next = 1'b1;
            rx_next   = RX_BREAK;
          end
        end else begin
          cnt_next = rx_cnt - CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxd_p1) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  f_state_t        f_state, f_next;
  logic [7:0]      sum, sum_next;
  logic [IW-1:0]   idx, idx_next;
  logic [IW-1:0]   len, len_next;
  logic [TW-1:0]   tcnt, tcnt_next;
  logic            wr_en_q, wr_en_next;
  logic [3:0]      wr_addr_q, addr_next;
  logic [7:0]      wr_data_q, data_next;
  logic            hold_q, hold_next;
  logic            busy_q, busy_next;
  logic            ok_q, ok_next;
  logic            err_q, err_next;
  logic            abort;

  // Frame parser state, RAM write port and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_state   <= F_SYNC;
      sum       <= '0;
      idx       <= '0;
      len       <= '0;
      tcnt      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      f_state   <= f_next;
      sum       <= sum_next;
      idx       <= idx_next;
      len       <= len_next;
      tcnt      <= tcnt_next;
      wr_en_q   <= wr_en_next;
      wr_addr_q <= addr_next;
      wr_data_q <= data_next;
      hold_q    <= hold_next;
      busy_q    <= busy_next;
      ok_q      <= ok_next;
      err_q     <= err_next;
    end
  end

  // Frame parser next state; any abort overrides the per-state decision
  always_comb begin
    f_next     = f_state;
    sum_next   = sum;
    idx_next   = idx;
    len_next   = len;
    tcnt_next  = '0;
    wr_en_next = 1'b0;
    addr_next  = wr_addr_q;
    data_next  = wr_data_q;
    hold_next  = hold_q;
    busy_next  = busy_q;
    ok_next    = ok_q;
    err_next   = err_q;
    abort      = 1'b0;
    if (busy_q && !byte_valid) tcnt_next = tcnt + TW'(1);
    unique case (f_state)
      F_SYNC: begin
        if (byte_valid && rx_shift == 8'hA5) begin
          hold_next = 1'b1;
          busy_next = 1'b1;
          ok_next   = 1'b0;
          err_next  = 1'b0;
          sum_next  = '0;
          idx_next  = '0;
          f_next    = F_LEN;
        end
      end
      F_LEN: begin
        if (byte_valid) begin
          if (rx_shift != 8'd0 && int'(rx_shift) <= DEPTH) begin
            len_next = IW'(rx_shift);
            sum_next = rx_shift;
            f_next   = F_DATA;
          end else begin
            abort = 1'b1;
          end
        end
      end
      F_DATA: begin
        if (byte_valid) begin
          wr_en_next = 1'b1;
          addr_next  = 4'(idx);
          data_next  = rx_shift;
          sum_next   = sum + rx_shift;
          idx_next   = idx + IW'(1);
          if ((idx + IW'(1)) == len) f_next = F_CHK;
        end
      end
      F_CHK: begin
        if (byte_valid) begin
          if (rx_shift == sum) begin
            ok_next   = 1'b1;
            hold_next = 1'b0;
            busy_next = 1'b0;
            f_next    = F_SYNC;
          end else begin
            abort = 1'b1;
          end
        end
      end
      default: f_next = F_SYNC;
    endcase
    if (busy_q && (frame_err || (!byte_valid && tcnt == TW'(TIMEOUT - 1)))) abort = 1'b1;
    if (abort) begin
      err_next   = 1'b1;
      busy_next  = 1'b0;
      wr_en_next = 1'b0;
      tcnt_next  = '0;
      f_next     = F_SYNC;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cpu_hold = hold_q;
  assign bus.busy     = busy_q;
  assign bus.load_ok  = ok_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: serial frames driven on rxd, RAM writes captured,
// results compared against a frame-level parser of the byte stream.
module tb_prog_loader;
  localparam int CLK_HZ  = 1600;
  localparam int BAUD    = 100;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [11:0] got[$];
  logic [11:0] exp_w[$];
  logic exp_ok, exp_err, exp_hold, exp_busy;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) got.push_back({bus.wr_addr, bus.wr_data});
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
    check({tag, "_hold"}, 32'(bus.cpu_hold), 32'(exp_hold));
    check({tag, "_ok"}, 32'(bus.load_ok), 32'(exp_ok));
    check({tag, "_err"}, 32'(bus.load_err), 32'(exp_err));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(got[i]), 32'(exp_w[i]));
  endtask

  task automatic model_abort();
    exp_err  = 1'b1;
    exp_busy = 1'b0;
    exp_ok   = 1'b0;
  endtask

  // Parse one frame from a byte list; cut means the stream was broken off (timeout/framing error)
  task automatic model(input logic [7:0] q[$], input bit cut);
    int i;
    int len;
    logic [7:0] s;
    exp_w.delete();
    i = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    if (i >= q.size()) return;
    i++;
    exp_busy = 1'b1; exp_hold = 1'b1; exp_ok = 1'b0; exp_err = 1'b0;
    if (i >= q.size()) begin if (cut) model_abort(); return; end
    len = int'(q[i]);
    s = q[i];
    i++;
    if (len < 1 || len > DEPTH) begin model_abort(); return; end
    for (int k = 0; k < len; k++) begin
      if (i >= q.size()) begin if (cut) model_abort(); return; end
      exp_w.push_back({4'(k), q[i]});
      s = s + q[i];
      i++;
    end
    if (i >= q.size()) begin if (cut) model_abort(); return; end
    if (q[i] == s) begin
      exp_ok = 1'b1; exp_hold = 1'b0; exp_busy = 1'b0;
    end else begin
      model_abort();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    bus.rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    bus.rxd = stop_ok;
    repeat (DIV) @(negedge clk);
    bus.rxd = 1'b1;
    repeat ($urandom_range(2, 20)) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] q[$], input bit cut, input int extra);
    repeat (extra + 4) @(negedge clk);
    model(q, cut);
    check_writes(tag);
    check_status(tag);
  endtask

  logic [7:0] q[$];
  logic [7:0] part[$];
  logic [7:0] s;
  int n;

  initial begin
    bus.rxd = 1'b1;
    rst = 1'b0;
    exp_ok = 1'b0; exp_err = 1'b0; exp_hold = 1'b0; exp_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check_status("rst");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // good frame, with a look at the status levels once A5 has been taken
    got.delete();
    q = '{8'hA5, 8'h03, 8'hA3, 8'h62, 8'h90, 8'h98};
    send_byte(8'hA5, 1'b1);
    check("good_mid_busy", 32'(bus.busy), 1);
    check("good_mid_hold", 32'(bus.cpu_hold), 1);
    part = '{8'h03, 8'hA3, 8'h62, 8'h90, 8'h98};
    send_seq(part);
    finish_frame("good", q, 1'b0, 0);

    // bad checksum then recovery
    got.delete();
    q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00};
    send_seq(q);
    finish_frame("badchk", q, 1'b0, 0);
    got.delete();
    q = '{8'hA5, 8'h01, 8'h5C, 8'h5D};
    send_seq(q);
    finish_frame("recover", q, 1'b0, 0);

    // length bounds
    got.delete();
    q = '{8'hA5, 8'h00};
    send_seq(q);
    finish_frame("len0", q, 1'b0, 0);
    got.delete();
    q = '{8'hA5, 8'h11};
    send_seq(q);
    finish_frame("len17", q, 1'b0, 0);
    got.delete();
    q = '{8'hA5, 8'h10};
    s = 8'h10;
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      s = s + q[q.size() - 1];
    end
    q.push_back(s);
    send_seq(q);
    finish_frame("len16", q, 1'b0, 0);

    // garbage before sync
    got.delete();
    q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hC3, 8'h3C, 8'h01};
    send_seq(q);
    finish_frame("garbage", q, 1'b0, 0);

    // short low glitch inside a frame must not become a byte
    got.delete();
    q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    part = '{8'hA5, 8'h01};
    send_seq(part);
    bus.rxd = 1'b0;
    repeat (5) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (40) @(negedge clk);
    part = '{8'h7E, 8'h7F};
    send_seq(part);
    finish_frame("glitch", q, 1'b0, 0);

    // stop bit forced low mid-frame
    got.delete();
    q = '{8'hA5, 8'h02, 8'h11};
    send_seq(q);
    send_byte(8'h22, 1'b0);
    finish_frame("ferr", q, 1'b1, 0);

    // inter-byte timeout
    got.delete();
    q = '{8'hA5, 8'h04, 8'h12};
    send_seq(q);
    finish_frame("timeout", q, 1'b1, TIMEOUT + 10);

    // reset in the middle of a frame, then a fresh frame
    got.delete();
    q = '{8'hA5, 8'h02, 8'h33};
    send_seq(q);
    finish_frame("prerst", q, 1'b0, 0);
    rst = 1'b0;
    #1;
    exp_ok = 1'b0; exp_err = 1'b0; exp_hold = 1'b0; exp_busy = 1'b0;
    check("midrst_wr_en", 32'(bus.wr_en), 0);
    check("midrst_wr_addr", 32'(bus.wr_addr), 0);
    check("midrst_wr_data", 32'(bus.wr_data), 0);
    check_status("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    got.delete();
    q = '{8'hA5, 8'h01, 8'h44, 8'h45};
    send_seq(q);
    finish_frame("postrst", q, 1'b0, 0);

    // randomized frames, optional garbage prefix and occasionally bad checksum
    for (int f = 0; f < 6; f++) begin
      got.delete();
      q.delete();
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        s = 8'($urandom_range(0, 255));
        if (s == 8'hA5) s = 8'h5A;
        q.push_back(s);
      end
      q.push_back(8'hA5);
      n = $urandom_range(1, DEPTH);
      q.push_back(8'(n));
      s = 8'(n);
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom_range(0, 255)));
        s = s + q[q.size() - 1];
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      q.push_back(s);
      send_seq(q);
      finish_frame($sformatf("rand%0d", f), q, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
